// File: rtl/cla_pipe_add.sv
// Pipelined carry-lookahead adder/subtractor: one WIDTH/STAGES-bit slice per stage,
// registered carry between slices, valid/ready handshake with bubble collapsing.
module cla_pipe_add #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;

  // Fully expanded lookahead: every carry is a flat OR of generate terms, no ripple chain.
  function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                            input logic ci);
    logic [SW-1:0] g;
    logic [SW-1:0] p;
    logic [SW:0]   c;
    logic          t;
    logic          prod;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SW; i++) begin
      t    = g[i];
      prod = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        t    = t | (prod & g[j]);
        prod = prod & p[j];
      end
      c[i+1] = t | (prod & ci);
    end
    return {c[SW], p ^ c[SW-1:0]};
  endfunction

  logic [STAGES-1:0] r_v;
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic [STAGES-1:0] r_c;
  logic              r_ovf;

  logic [WIDTH-1:0]  w_ia [STAGES];
  logic [WIDTH-1:0]  w_ib [STAGES];
  logic [WIDTH-1:0]  w_is [STAGES];
  logic [WIDTH-1:0]  w_ns [STAGES];
  logic [SW:0]       w_res [STAGES];
  logic [STAGES-1:0] w_ic;
  logic [STAGES-1:0] w_iv;
  logic [STAGES-1:0] w_adv;
  logic              w_novf;

  // A stage may advance when it is empty or everything downstream of it can move.
  always_comb begin
    logic nxt;
    nxt   = out_ready;
    w_adv = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      nxt      = ~r_v[k] | nxt;
      w_adv[k] = nxt;
    end
  end

  always_comb begin
    w_ia[0] = a;
    w_ib[0] = b ^ {WIDTH{op_sub}};
    w_ic[0] = op_sub | c_in;
    w_is[0] = '0;
    w_iv[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_ia[k] = r_a[k-1];
      w_ib[k] = r_b[k-1];
      w_ic[k] = r_c[k-1];
      w_is[k] = r_s[k-1];
      w_iv[k] = r_v[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_res[k]              = cla_slice(w_ia[k][k*SW +: SW], w_ib[k][k*SW +: SW], w_ic[k]);
      w_ns[k]               = w_is[k];
      w_ns[k][k*SW +: SW]   = w_res[k][SW-1:0];
    end
    w_novf = (w_ia[STAGES-1][WIDTH-1] == w_ib[STAGES-1][WIDTH-1]) &&
             (w_ns[STAGES-1][WIDTH-1] != w_ia[STAGES-1][WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_adv[k]) r_v[k] <= w_iv[k];
      end
    end
  end

  // Data only moves with a valid token, so idle operands never disturb the outputs.
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES - 1; k++) begin
      if (w_adv[k] && w_iv[k]) begin
        r_a[k] <= w_ia[k];
        r_b[k] <= w_ib[k];
        r_s[k] <= w_ns[k];
        r_c[k] <= w_res[k][SW];
      end
    end
    if (!rst_n) begin
      r_s[STAGES-1] <= '0;
      r_c[STAGES-1] <= 1'b0;
      r_ovf         <= 1'b0;
    end else if (w_adv[STAGES-1] && w_iv[STAGES-1]) begin
      r_s[STAGES-1] <= w_ns[STAGES-1];
      r_c[STAGES-1] <= w_res[STAGES-1][SW];
      r_ovf         <= w_novf;
    end
  end

  assign in_ready  = rst_n & w_adv[0];
  assign out_valid = r_v[STAGES-1];
  assign s         = r_s[STAGES-1];
  assign c_out     = r_c[STAGES-1];
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_pipe_add.sv
// Bench for cla_pipe_add: directed 32/4 sequence plus random sweeps on 8/2 and 64/8 instances,
// with queue scoreboards filled at input handshake and drained at output handshake.
module tb_cla_pipe_add;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, c_in, op_sub, out_valid, out_ready, c_out, ovf;
  logic [31:0] a, b, s;
  logic        x_in_valid, x_in_ready, x_c_in, x_op_sub, x_out_valid, x_out_ready, x_c_out, x_ovf;
  logic [7:0]  x_a, x_b, x_s;
  logic        y_in_valid, y_in_ready, y_c_in, y_op_sub, y_out_valid, y_out_ready, y_c_out, y_ovf;
  logic [63:0] y_a, y_b, y_s;

  cla_pipe_add #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .c_in(c_in), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready), .s(s),
    .c_out(c_out), .ovf(ovf));

  cla_pipe_add #(.WIDTH(8), .STAGES(2)) dut_x (
    .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(x_in_ready), .a(x_a), .b(x_b),
    .c_in(x_c_in), .op_sub(x_op_sub), .out_valid(x_out_valid), .out_ready(x_out_ready), .s(x_s),
    .c_out(x_c_out), .ovf(x_ovf));

  cla_pipe_add #(.WIDTH(64), .STAGES(8)) dut_y (
    .clk(clk), .rst_n(rst_n), .in_valid(y_in_valid), .in_ready(y_in_ready), .a(y_a), .b(y_b),
    .c_in(y_c_in), .op_sub(y_op_sub), .out_valid(y_out_valid), .out_ready(y_out_ready), .s(y_s),
    .c_out(y_c_out), .ovf(y_ovf));

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        o;
    int          cyc;
    logic        lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int n_out0 = 0, n_out1 = 0, n_out2 = 0, n_in1 = 0, n_in2 = 0;
  logic [31:0] pend_s;
  logic        pend_c, pend_o, lat0, lat_sw;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain (w+1)-bit arithmetic on the effective operands.
  function automatic logic [65:0] model(input int w, input logic [63:0] ta, input logic [63:0] tb,
                                        input logic tc, input logic tsub);
    logic [63:0] m, bb, aa;
    logic [64:0] full;
    logic        ci;
    m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = ta & m;
    bb   = (tsub ? ~tb : tb) & m;
    ci   = tsub ? 1'b1 : tc;
    full = {1'b0, aa} + {1'b0, bb} + {64'd0, ci};
    return {(aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]), full[w], full[63:0] & m};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) q0.delete();
    else begin
      if (out_valid && out_ready) begin
        n_out0++;
        chk("q0_nonempty", 64'(q0.size() != 0), 64'd1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          chk("s", 64'(s), e.s);
          chk("c_out", 64'(c_out), 64'(e.c));
          chk("ovf", 64'(ovf), 64'(e.o));
          if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd4);
        end
      end
      if (in_valid && in_ready) begin
        e.s = {32'd0, pend_s}; e.c = pend_c; e.o = pend_o; e.cyc = cyc; e.lat = lat0;
        q0.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic [65:0] r;
    if (!rst_n) q1.delete();
    else begin
      if (x_out_valid && x_out_ready) begin
        n_out1++;
        chk("q1_nonempty", 64'(q1.size() != 0), 64'd1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk("s_w8", 64'(x_s), e.s);
          chk("c_out_w8", 64'(x_c_out), 64'(e.c));
          chk("ovf_w8", 64'(x_ovf), 64'(e.o));
          if (e.lat) chk("latency_w8", 64'(cyc - e.cyc), 64'd2);
        end
      end
      if (x_in_valid && x_in_ready) begin
        r = model(8, 64'(x_a), 64'(x_b), x_c_in, x_op_sub);
        e.s = r[63:0]; e.c = r[64]; e.o = r[65]; e.cyc = cyc; e.lat = lat_sw;
        q1.push_back(e);
        n_in1++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic [65:0] r;
    if (!rst_n) q2.delete();
    else begin
      if (y_out_valid && y_out_ready) begin
        n_out2++;
        chk("q2_nonempty", 64'(q2.size() != 0), 64'd1);
        if (q2.size() != 0) begin
          e = q2.pop_front();
          chk("s_w64", y_s, e.s);
          chk("c_out_w64", 64'(y_c_out), 64'(e.c));
          chk("ovf_w64", 64'(y_ovf), 64'(e.o));
          if (e.lat) chk("latency_w64", 64'(cyc - e.cyc), 64'd8);
        end
      end
      if (y_in_valid && y_in_ready) begin
        r = model(64, y_a, y_b, y_c_in, y_op_sub);
        e.s = r[63:0]; e.c = r[64]; e.o = r[65]; e.cyc = cyc; e.lat = lat_sw;
        q2.push_back(e);
        n_in2++;
      end
    end
  end

  task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tc, input logic tsub,
                      input logic [31:0] es, input logic ec, input logic eo);
    int k;
    k = 0;
    a = ta; b = tb; c_in = tc; op_sub = tsub;
    pend_s = es; pend_c = ec; pend_o = eo;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      k++;
      @(negedge clk);
    end
    chk("accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain0();
    int k;
    k = 0;
    while (q0.size() != 0 && k < 60) begin
      k++;
      @(negedge clk);
    end
    chk("drain", 64'(q0.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_sweep(input logic rnd_ready);
    x_in_valid = ($urandom_range(0, 3) != 0);
    x_a = 8'($urandom); x_b = 8'($urandom);
    x_c_in = 1'($urandom_range(0, 1)); x_op_sub = 1'($urandom_range(0, 1));
    y_in_valid = ($urandom_range(0, 3) != 0);
    y_a = {$urandom, $urandom}; y_b = {$urandom, $urandom};
    y_c_in = 1'($urandom_range(0, 1)); y_op_sub = 1'($urandom_range(0, 1));
    x_out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    y_out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  initial begin
    int base;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; op_sub = 1'b0; out_ready = 1'b1;
    pend_s = '0; pend_c = 1'b0; pend_o = 1'b0; lat0 = 1'b0; lat_sw = 1'b0;
    x_in_valid = 1'b0; x_a = '0; x_b = '0; x_c_in = 1'b0; x_op_sub = 1'b0; x_out_ready = 1'b1;
    y_in_valid = 1'b0; y_a = '0; y_b = '0; y_c_in = 1'b0; y_op_sub = 1'b0; y_out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_c_out", 64'(c_out), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    lat0 = 1'b1;
    send(32'd65500,   32'd100,     1'b0, 1'b0, 32'd65600,   1'b0, 1'b0);
    send(32'd65535,   32'd11111,   1'b0, 1'b0, 32'd76646,   1'b0, 1'b0);
    send(32'd1021201, 32'd1457454, 1'b0, 1'b0, 32'd2478655, 1'b0, 1'b0);
    send(32'd6553500, 32'd1111145, 1'b0, 1'b0, 32'd7664645, 1'b0, 1'b0);
    drain0();

    send(32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);
    send(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    send(32'd65555535, 32'd11114541, 1'b0, 1'b1, 32'd54440994, 1'b1, 1'b0);
    send(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    send(32'h80000000, 32'd1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    send(32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    drain0();

    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom; c_in = 1'b1;
      @(negedge clk);
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      chk("idle_s", 64'(s), 64'hFFFFFFFE);
      @(posedge clk);
      #1;
    end

    lat0 = 1'b0; out_ready = 1'b0; base = n_out0;
    for (int i = 1; i <= 4; i++)
      send(32'(i * 1000), 32'(i * 7), 1'b0, 1'b0, 32'(i * 1007), 1'b0, 1'b0);
    a = 32'd5000; b = 32'd35; c_in = 1'b0; op_sub = 1'b0;
    pend_s = 32'd5035; pend_c = 1'b0; pend_o = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_s_stable", 64'(s), 64'd1007);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(32'd5000, 32'd35, 1'b0, 1'b0, 32'd5035, 1'b0, 1'b0);
    send(32'd6000, 32'd42, 1'b0, 1'b0, 32'd6042, 1'b0, 1'b0);
    drain0();
    chk("bp_count", 64'(n_out0 - base), 64'd6);

    base = n_out0;
    send(32'd11, 32'd22, 1'b0, 1'b0, 32'd33,  1'b0, 1'b0);
    send(32'd44, 32'd55, 1'b0, 1'b0, 32'd99,  1'b0, 1'b0);
    send(32'd66, 32'd77, 1'b0, 1'b0, 32'd143, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready_rel", 64'(in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    chk("midrst_count", 64'(n_out0 - base), 64'd0);
    @(posedge clk);
    #1 lat0 = 1'b1;
    send(32'd123, 32'd456, 1'b0, 1'b0, 32'd579, 1'b0, 1'b0);
    drain0();
    chk("midrst_count_after", 64'(n_out0 - base), 64'd1);

    lat_sw = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_sweep(1'b0);
      @(posedge clk);
      #1;
    end
    x_in_valid = 1'b0; y_in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 lat_sw = 1'b0;
    for (int i = 0; i < 150; i++) begin
      drive_sweep(1'b1);
      @(posedge clk);
      #1;
    end
    x_in_valid = 1'b0; y_in_valid = 1'b0; x_out_ready = 1'b1; y_out_ready = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("sweep_w8_drained", 64'(q1.size()), 64'd0);
    chk("sweep_w64_drained", 64'(q2.size()), 64'd0);
    chk("sweep_w8_count", 64'(n_out1), 64'(n_in1));
    chk("sweep_w64_count", 64'(n_out2), 64'(n_in2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/cla_pipe_add.md
CLA_PIPE_ADD -- requirements
Module: cla_pipe_add

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits; legal values 8 to 64 inclusive.
REQ-002 Parameter STAGES, default 4: number of pipeline stages; WIDTH SHALL be an integer multiple of STAGES.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low, sampled on rising edge of clk.
REQ-005 in_valid  input  1  operand set on a, b, c_in, op_sub is valid this cycle.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 c_in  input  1  carry in; used only when op_sub=0.
REQ-010 op_sub  input  1  0 = add (a+b+c_in), 1 = subtract (a-b).
REQ-011 out_valid  output  1  s, c_out, ovf hold a valid result.
REQ-012 out_ready  input  1  downstream consumes the result this cycle.
REQ-013 s  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-014 c_out  output  1  carry out of the MSB; in subtract mode, 1 means no borrow (a >= b unsigned).
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 Transfer in SHALL occur on a rising edge where in_valid=1 and in_ready=1; transfer out SHALL occur where out_valid=1 and out_ready=1.
REQ-017 Subtract SHALL be computed as a + ~b + 1; c_in SHALL be ignored when op_sub=1.
REQ-018 The adder SHALL be split into STAGES slices of WIDTH/STAGES bits; slice k SHALL be computed in pipeline stage k by a carry-lookahead adder fed by the registered carry from slice k-1.
REQ-019 Operand bits for slices not yet computed SHALL be carried forward in stage registers; completed sum slices SHALL be carried forward alongside them.
REQ-020 Each stage SHALL hold one valid bit; the final stage's registers SHALL drive s, c_out, ovf and out_valid directly.
REQ-021 With out_ready held at 1, latency from in transfer to out_valid=1 SHALL be exactly STAGES cycles, with throughput of one result per cycle.
REQ-022 Stage k SHALL load from stage k-1 when stage k is empty or stage k is unloading in the same cycle (bubble collapsing); in_ready SHALL equal the stage-0 load condition.
REQ-023 When a stage is neither loading nor unloading, it SHALL hold its contents unchanged; results SHALL never be dropped or duplicated, and results SHALL leave in input order.
REQ-024 While out_valid=1 and out_ready=0, s, c_out and ovf SHALL remain stable.
REQ-025 ovf SHALL be 1 iff the effective operands a and (op_sub ? ~b : b) have equal MSBs and s MSB differs from them.
REQ-026 A simultaneous in transfer and out transfer with a full pipeline SHALL be accepted with no bubble.
REQ-027 in_ready SHALL be 0 only when all STAGES stages are valid and out_ready=0.
REQ-028 Operand values presented with in_valid=0 SHALL have no effect on outputs.

Reset
REQ-029 On a rising edge with rst_n=0, all stage valid bits SHALL clear; out_valid=0, s=0, c_out=0, ovf=0 on the following cycle.
REQ-030 Reset SHALL abort any in-flight operations, and their results SHALL never appear.
REQ-031 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-032 Data-path registers other than the outputs and valid bits need not be reset.

Verification (WIDTH=32, STAGES=4 unless noted)
REQ-033 Add stream, out_ready=1: 65500+100, 65535+11111, 1021201+1457454, 6553500+1111145 on consecutive cycles -> s = 65600, 76646, 2478655, 7664645 on four consecutive cycles, first result 4 cycles after first input, c_out=0, ovf=0.
REQ-034 Carry/overflow corners: 0xFFFFFFFF+0, c_in=1 -> s=0, c_out=1, ovf=0; 0x7FFFFFFF+1 -> s=0x80000000, c_out=0, ovf=1.
REQ-035 Subtract: 65555535-11114541 -> s=54440994, c_out=1, ovf=0; 5-7 -> s=0xFFFFFFFE, c_out=0; 0x80000000-1 -> s=0x7FFFFFFF, ovf=1; c_in=1 during subtract has no effect.
REQ-036 Backpressure: 6 back-to-back inputs with out_ready=0 -> in_ready drops after 4 accepted; outputs stable; raising out_ready drains all 6 in order, with no loss or duplication.
REQ-037 Reset mid-stream: 3 inputs accepted, rst_n=0 for 1 cycle -> out_valid stays 0; the next input yields only its own result after 4 cycles.
REQ-038 Parameter sweep: WIDTH=8, STAGES=2 and WIDTH=64, STAGES=8 with random operands and random out_ready -> every result matches the reference model, with latency = STAGES cycles when there is no stall.
